// File: rtl/tetris_pkg.sv
// Shared constants, state encoding and field addressing helpers for the
// line-clear stage between game logic and the VGA controller.
package tetris_pkg;

  localparam int unsigned ROWS    = 20;
  localparam int unsigned COLS    = 10;
  localparam int unsigned CW      = 2;
  localparam int unsigned SCORE_W = 32;

  localparam int unsigned AWARD_1 = 40;
  localparam int unsigned AWARD_2 = 100;
  localparam int unsigned AWARD_3 = 300;
  localparam int unsigned AWARD_4 = 1200;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SHIFT,
    SCORE,
    DONE
  } rc_state_t;

  // Bit offset of a row inside a flattened field.
  function automatic int unsigned row_base(input int unsigned row, input int unsigned row_w);
    return row * row_w;
  endfunction

endpackage

// File: rtl/row_full_check.sv
// Combinational test that every cell of one playfield row is occupied.
module row_full_check #(
  parameter int unsigned COLS = tetris_pkg::COLS,
  parameter int unsigned CW   = tetris_pkg::CW
) (
  input  logic [COLS*CW-1:0] row,
  output logic               full
);

  always_comb begin
    full = 1'b1;
    for (int unsigned c = 0; c < COLS; c++) begin
      if (row[c*CW +: CW] == '0) full = 1'b0;
    end
  end

endmodule

// File: rtl/row_clear_engine.sv
// Captures the locked field, removes full rows bottom-up one shift per cycle,
// then publishes the cleaned field, line count and saturating score.
module row_clear_engine #(
  parameter int unsigned ROWS    = tetris_pkg::ROWS,
  parameter int unsigned COLS    = tetris_pkg::COLS,
  parameter int unsigned CW      = tetris_pkg::CW,
  parameter int unsigned SCORE_W = tetris_pkg::SCORE_W
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ROWS*COLS*CW-1:0] field_in,
  output logic                    busy,
  output logic                    done,
  output logic [ROWS*COLS*CW-1:0] field_out,
  output logic [4:0]              lines_cleared,
  output logic [SCORE_W-1:0]      score
);

  import tetris_pkg::*;

  localparam int unsigned ROW_W   = COLS * CW;
  localparam int unsigned FIELD_W = ROWS * ROW_W;
  localparam int unsigned PTR_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned K_W     = 5;

  rc_state_t state, state_next;

  logic [FIELD_W-1:0] work;
  logic [FIELD_W-1:0] work_shifted;
  logic [ROW_W-1:0]   cur_row;
  logic [PTR_W-1:0]   ptr;
  logic [K_W-1:0]     k;
  logic               row_full;
  logic               load_c, dec_c, shift_c, score_c;
  logic [SCORE_W-1:0] award;
  logic [SCORE_W:0]   sum_wide;
  logic [SCORE_W-1:0] score_sum;

  always_comb cur_row = work[row_base(32'(ptr), ROW_W) +: ROW_W];

  row_full_check #(
    .COLS (COLS),
    .CW   (CW)
  ) u_row_full_check (
    .row  (cur_row),
    .full (row_full)
  );

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = SCAN;
      SCAN: begin
        if (row_full)        state_next = SHIFT;
        else if (ptr == '0)  state_next = SCORE;
      end
      SHIFT:   state_next = SCAN;
      SCORE:   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath controls decoded from the current state
  always_comb begin
    load_c  = 1'b0;
    dec_c   = 1'b0;
    shift_c = 1'b0;
    score_c = 1'b0;
    case (state)
      IDLE:    load_c  = start;
      SCAN:    dec_c   = !row_full && (ptr != '0);
      SHIFT:   shift_c = 1'b1;
      SCORE:   score_c = 1'b1;
      default: ;
    endcase
  end

  // Rows at or above ptr drop by one; rows below ptr are untouched.
  always_comb begin
    work_shifted = work;
    work_shifted[0 +: ROW_W] = '0;
    for (int unsigned r = 1; r < ROWS; r++) begin
      if (PTR_W'(r) <= ptr)
        work_shifted[row_base(r, ROW_W) +: ROW_W] = work[row_base(r - 1, ROW_W) +: ROW_W];
    end
  end

  always_comb begin
    case (k)
      K_W'(0): award = '0;
      K_W'(1): award = SCORE_W'(AWARD_1);
      K_W'(2): award = SCORE_W'(AWARD_2);
      K_W'(3): award = SCORE_W'(AWARD_3);
      default: award = SCORE_W'(AWARD_4);
    endcase
    sum_wide  = {1'b0, score} + {1'b0, award};
    score_sum = sum_wide[SCORE_W] ? '1 : sum_wide[SCORE_W-1:0];
  end

  // busy/done are registered from the next state so they align with it.
  always_ff @(posedge clock) begin
    if (reset) begin
      busy          <= 1'b0;
      done          <= 1'b0;
      field_out     <= '0;
      lines_cleared <= '0;
      score         <= '0;
      work          <= '0;
      ptr           <= '0;
      k             <= '0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state_next == DONE);
      if (load_c) begin
        work <= field_in;
        ptr  <= PTR_W'(ROWS - 1);
        k    <= '0;
      end
      if (dec_c) ptr <= ptr - PTR_W'(1);
      if (shift_c) begin
        work <= work_shifted;
        k    <= k + K_W'(1);
      end
      if (score_c) begin
        score         <= score_sum;
        field_out     <= work;
        lines_cleared <= k;
      end
    end
  end

endmodule
